fetch_unit: RTL and testbench

- Instruction-fetch stage of the pipelined RV32I core; the producer end of the instruction stream the decode-stage controller consumes, and the consumer of the controller's PCSrcE redirect.
- Owns the PC register, issues requests to instruction memory over a valid/ready request channel with variable-latency response, and drives the IF/ID pipeline register (InstrD, PCD, PCPlus4D, ValidD).
- Handles decode stalls, decode flushes and execute-stage redirects, discarding any in-flight wrong-path fetch.

---
 rtl/fetch_unit.sv | 183 ++++++++++++++++++
 tb/tb_fetch_unit.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns PCF, issues single-outstanding imem requests, drives IF/ID.
// Optional macro FETCH_PERF_CNT_EN adds fetch_count / drop_count performance counters.
module fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        StallD,
    input  logic        FlushD,
    input  logic        PCSrcE,
    input  logic [31:0] PCTargetE,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic [31:0] PCF,
    output logic [31:0] InstrD,
    output logic [31:0] PCD,
    output logic [31:0] PCPlus4D,
    output logic        ValidD
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] fetch_count,
    output logic [31:0] drop_count
`endif
);

    // state  | meaning
    // S_REQ  | request valid at PCF, waiting for imem_req_ready
    // S_WAIT | request accepted, waiting for the response
    // S_HOLD | response captured in holding buffer while decode stalls
    // S_DROP | wrong-path request in flight, its response will be discarded
    typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD, S_DROP} state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_pcf;
    logic [31:0] w_pcf_nxt;
    logic [31:0] r_req_pc;
    logic [31:0] w_req_pc_nxt;
    logic [31:0] r_buf;
    logic [31:0] w_buf_nxt;
    logic [31:0] r_instr_d;
    logic [31:0] r_pc_d;
    logic [31:0] r_pcplus4_d;
    logic        r_valid_d;

    logic        w_deliver;
    logic [31:0] w_deliver_instr;
    logic        w_drop;
    logic [31:0] w_req_pc_plus4;
    logic        w_unused_tgt_lsb;

    assign w_req_pc_plus4   = r_req_pc + 32'd4;
    assign w_unused_tgt_lsb = ^PCTargetE[1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_REQ;
            r_pcf    <= RESET_PC;
            r_req_pc <= RESET_PC;
            r_buf    <= NOP_INSTR;
        end else begin
            r_state  <= w_state_nxt;
            r_pcf    <= w_pcf_nxt;
            r_req_pc <= w_req_pc_nxt;
            r_buf    <= w_buf_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_pcf_nxt       = r_pcf;
        w_req_pc_nxt    = r_req_pc;
        w_buf_nxt       = r_buf;
        w_deliver       = 1'b0;
        w_deliver_instr = imem_rsp_data;
        w_drop          = 1'b0;
        imem_req_valid  = 1'b0;

        case (r_state)
            S_REQ: begin
                imem_req_valid = 1'b1;
                if (imem_req_ready) begin
                    w_req_pc_nxt = r_pcf;
                    w_state_nxt  = PCSrcE ? S_DROP : S_WAIT;
                end
            end
            S_WAIT: begin
                if (imem_rsp_valid) begin
                    if (PCSrcE) begin
                        w_drop      = 1'b1;
                        w_state_nxt = S_REQ;
                    end else if (!StallD) begin
                        w_deliver   = 1'b1;
                        w_pcf_nxt   = w_req_pc_plus4;
                        w_state_nxt = S_REQ;
                    end else begin
                        w_buf_nxt   = imem_rsp_data;
                        w_state_nxt = S_HOLD;
                    end
                end else if (PCSrcE) begin
                    w_state_nxt = S_DROP;
                end
            end
            S_HOLD: begin
                if (PCSrcE) begin
                    w_drop      = 1'b1;
                    w_state_nxt = S_REQ;
                end else if (!StallD) begin
                    w_deliver       = 1'b1;
                    w_deliver_instr = r_buf;
                    w_pcf_nxt       = w_req_pc_plus4;
                    w_state_nxt     = S_REQ;
                end
            end
            S_DROP: begin
                // a redirect here only moves PCF; the stale response must still be drained
                if (imem_rsp_valid) begin
                    w_drop      = 1'b1;
                    w_state_nxt = S_REQ;
                end
            end
            default: w_state_nxt = S_REQ;
        endcase

        if (PCSrcE) begin
            w_pcf_nxt = {PCTargetE[31:2], 2'b00};
        end
    end

    // Flush beats stall; a redirect or an idle cycle inserts a bubble unless decode stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_instr_d   <= NOP_INSTR;
            r_pc_d      <= '0;
            r_pcplus4_d <= '0;
            r_valid_d   <= 1'b0;
        end else if (FlushD || (!StallD && !w_deliver)) begin
            r_instr_d   <= NOP_INSTR;
            r_pc_d      <= '0;
            r_pcplus4_d <= '0;
            r_valid_d   <= 1'b0;
        end else if (!StallD) begin
            r_instr_d   <= w_deliver_instr;
            r_pc_d      <= r_req_pc;
            r_pcplus4_d <= w_req_pc_plus4;
            r_valid_d   <= 1'b1;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] r_fetch_count;
    logic [31:0] r_drop_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fetch_count <= '0;
            r_drop_count  <= '0;
        end else begin
            if (w_deliver && !FlushD) begin
                r_fetch_count <= r_fetch_count + 32'd1;
            end
            if (w_drop) begin
                r_drop_count <= r_drop_count + 32'd1;
            end
        end
    end

    assign fetch_count = r_fetch_count;
    assign drop_count  = r_drop_count;
`endif

    assign imem_addr = r_pcf;
    assign PCF       = r_pcf;
    assign InstrD    = r_instr_d;
    assign PCD       = r_pc_d;
    assign PCPlus4D  = r_pcplus4_d;
    assign ValidD    = r_valid_d;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: an imem model with configurable latency pushes every response
// into a scoreboard queue; each test pops the entries it expects to see in IF/ID.
`timescale 1ns/1ps
module tb_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        StallD = 1'b0;
    logic        FlushD = 1'b0;
    logic        PCSrcE = 1'b0;
    logic [31:0] PCTargetE = '0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic [31:0] PCF;
    logic [31:0] InstrD;
    logic [31:0] PCD;
    logic [31:0] PCPlus4D;
    logic        ValidD;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_count;
    logic [31:0] drop_count;
`endif

    int errors = 0;
    int checks = 0;
    int n_deliv = 0;
    int n_drop = 0;
    int mem_lat = 1;
    logic [63:0] exp_q[$];

    fetch_unit dut (
        .clk(clk),
        .rst_n(rst_n),
        .StallD(StallD),
        .FlushD(FlushD),
        .PCSrcE(PCSrcE),
        .PCTargetE(PCTargetE),
        .imem_req_valid(imem_req_valid),
        .imem_req_ready(imem_req_ready),
        .imem_addr(imem_addr),
        .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data(imem_rsp_data),
        .PCF(PCF),
        .InstrD(InstrD),
        .PCD(PCD),
        .PCPlus4D(PCPlus4D),
        .ValidD(ValidD)
`ifdef FETCH_PERF_CNT_EN
        ,
        .fetch_count(fetch_count),
        .drop_count(drop_count)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a == 32'h0) ? 32'h0050_0093 : (a ^ 32'h5A00_0000);
    endfunction

    // Memory samples requests just after each falling edge, so the response for a
    // request accepted at rising edge k is presented for rising edge k+mem_lat.
    initial begin : imem_model
        int cnt;
        logic pend;
        logic [31:0] addr;
        cnt = 0;
        pend = 1'b0;
        addr = '0;
        forever begin
            @(negedge clk);
            #1;
            imem_rsp_valid = 1'b0;
            if (!rst_n) begin
                pend = 1'b0;
            end else begin
                if (pend) begin
                    cnt--;
                    if (cnt == 0) begin
                        imem_rsp_valid = 1'b1;
                        imem_rsp_data = mem_word(addr);
                        exp_q.push_back({addr, mem_word(addr)});
                        pend = 1'b0;
                    end
                end
                if (imem_req_valid && imem_req_ready) begin
                    pend = 1'b1;
                    cnt = mem_lat;
                    addr = imem_addr;
                end
            end
        end
    end

    task automatic wait_valid(input int max_cyc, output int n, output bit ok);
        ok = 1'b0;
        n = 0;
        while (n < max_cyc && !ok) begin
            @(negedge clk);
            n++;
            if (ValidD === 1'b1) ok = 1'b1;
        end
    endtask

    task automatic pop_exp(output logic [31:0] a, output logic [31:0] d);
        logic [63:0] e;
        e = '0;
        if (exp_q.size() > 0) e = exp_q.pop_front();
        a = e[63:32];
        d = e[31:0];
    endtask

    task automatic test_reset();
        @(negedge clk);
        @(negedge clk);
        checks++; if (PCF !== 32'h0) begin errors++; $display("FAIL reset_pcf: got %h expected %h", PCF, 32'h0); end
        checks++; if (imem_req_valid !== 1'b1) begin errors++; $display("FAIL reset_req_valid: got %b expected 1", imem_req_valid); end
        checks++; if (ValidD !== 1'b0) begin errors++; $display("FAIL reset_validd: got %b expected 0", ValidD); end
        checks++; if (InstrD !== NOP) begin errors++; $display("FAIL reset_instrd: got %h expected %h", InstrD, NOP); end
        checks++; if (PCD !== 32'h0 || PCPlus4D !== 32'h0) begin errors++; $display("FAIL reset_pcd: got %h/%h expected 0/0", PCD, PCPlus4D); end
`ifdef FETCH_PERF_CNT_EN
        checks++; if (fetch_count !== 32'h0 || drop_count !== 32'h0) begin errors++; $display("FAIL reset_counters: got %0d/%0d expected 0/0", fetch_count, drop_count); end
`endif
    endtask

    task automatic test_first_fetch();
        int n; bit ok; logic [31:0] a, d;
        imem_req_ready = 1'b1;
        rst_n = 1'b1;
        wait_valid(10, n, ok);
        imem_req_ready = 1'b0;
        pop_exp(a, d);
        checks++; if (!ok) begin errors++; $display("FAIL first_timeout: got no ValidD expected ValidD within 10 cycles"); end
        checks++; if (n != 2) begin errors++; $display("FAIL first_latency: got %0d cycles expected 2", n); end
        checks++; if (InstrD !== 32'h0050_0093) begin errors++; $display("FAIL first_instr: got %h expected %h", InstrD, 32'h0050_0093); end
        checks++; if (PCD !== 32'h0 || PCPlus4D !== 32'h4) begin errors++; $display("FAIL first_pcd: got %h/%h expected 0/4", PCD, PCPlus4D); end
        checks++; if (PCF !== 32'h4) begin errors++; $display("FAIL first_pcf: got %h expected 4", PCF); end
        checks++; if (a !== 32'h0) begin errors++; $display("FAIL first_req_addr: got %h expected 0", a); end
        n_deliv++;
    endtask

    task automatic test_req_backpressure();
        int n; bit ok; logic [31:0] a, d;
        PCSrcE = 1'b1;
        PCTargetE = 32'h10;
        @(negedge clk);
        PCSrcE = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++; if (imem_addr !== 32'h10 || imem_req_valid !== 1'b1 || ValidD !== 1'b0) begin
                errors++; $display("FAIL bp_hold_%0d: got addr=%h valid=%b ValidD=%b expected 10/1/0", i, imem_addr, imem_req_valid, ValidD);
            end
            @(negedge clk);
        end
        imem_req_ready = 1'b1;
        wait_valid(10, n, ok);
        imem_req_ready = 1'b0;
        pop_exp(a, d);
        checks++; if (!ok || n != 2) begin errors++; $display("FAIL bp_latency: got ok=%b n=%0d expected ok=1 n=2", ok, n); end
        checks++; if (InstrD !== d || PCD !== 32'h10 || PCPlus4D !== 32'h14) begin
            errors++; $display("FAIL bp_ifid: got %h/%h/%h expected %h/10/14", InstrD, PCD, PCPlus4D, d);
        end
        checks++; if (PCF !== 32'h14) begin errors++; $display("FAIL bp_pcf: got %h expected 14", PCF); end
        n_deliv++;
    endtask

    task automatic test_stall_hold();
        int n; bit ok; logic [31:0] a, d, d2;
        imem_req_ready = 1'b1;
        wait_valid(10, n, ok);
        StallD = 1'b1;
        pop_exp(a, d);
        checks++; if (!ok || InstrD !== d || PCD !== 32'h14) begin errors++; $display("FAIL stall_pre: got ok=%b %h/%h expected %h/14", ok, InstrD, PCD, d); end
        n_deliv++;
        @(negedge clk);
        imem_req_ready = 1'b0;
        checks++; if (ValidD !== 1'b1 || InstrD !== d || PCD !== 32'h14) begin errors++; $display("FAIL stall_wait: got %b %h/%h expected 1 %h/14", ValidD, InstrD, PCD, d); end
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++; if (imem_req_valid !== 1'b0 || ValidD !== 1'b1 || InstrD !== d || PCD !== 32'h14 || PCF !== 32'h18) begin
                errors++; $display("FAIL stall_hold_%0d: got req=%b V=%b %h/%h pcf=%h expected 0 1 %h/14 18", i, imem_req_valid, ValidD, InstrD, PCD, PCF, d);
            end
        end
        StallD = 1'b0;
        @(negedge clk);
        pop_exp(a, d2);
        checks++; if (ValidD !== 1'b1 || InstrD !== d2) begin errors++; $display("FAIL stall_release_instr: got %b %h expected 1 %h", ValidD, InstrD, d2); end
        checks++; if (PCD !== 32'h18 || PCPlus4D !== 32'h1C || PCF !== 32'h1C) begin
            errors++; $display("FAIL stall_release_pc: got %h/%h/%h expected 18/1c/1c", PCD, PCPlus4D, PCF);
        end
        checks++; if (a !== 32'h18) begin errors++; $display("FAIL stall_req_addr: got %h expected 18", a); end
        n_deliv++;
    endtask

    task automatic test_redirect_wait();
        int n; bit ok; logic [31:0] a, d;
        mem_lat = 2;
        imem_req_ready = 1'b1;
        @(negedge clk);
        imem_req_ready = 1'b0;
        PCSrcE = 1'b1;
        PCTargetE = 32'h0000_0103;
        @(negedge clk);
        PCSrcE = 1'b0;
        checks++; if (PCF !== 32'h100 || imem_req_valid !== 1'b0 || ValidD !== 1'b0) begin
            errors++; $display("FAIL redir_drop: got pcf=%h req=%b V=%b expected 100/0/0", PCF, imem_req_valid, ValidD);
        end
        @(negedge clk);
        checks++; if (ValidD !== 1'b0 || imem_req_valid !== 1'b1 || imem_addr !== 32'h100) begin
            errors++; $display("FAIL redir_discard: got V=%b req=%b addr=%h expected 0/1/100", ValidD, imem_req_valid, imem_addr);
        end
        pop_exp(a, d);
        n_drop++;
        mem_lat = 1;
        imem_req_ready = 1'b1;
        wait_valid(10, n, ok);
        imem_req_ready = 1'b0;
        pop_exp(a, d);
        checks++; if (!ok || n != 2 || InstrD !== d) begin errors++; $display("FAIL redir_fetch: got ok=%b n=%0d %h expected 1/2/%h", ok, n, InstrD, d); end
        checks++; if (PCD !== 32'h100 || PCPlus4D !== 32'h104 || PCF !== 32'h104) begin
            errors++; $display("FAIL redir_pc: got %h/%h/%h expected 100/104/104", PCD, PCPlus4D, PCF);
        end
        n_deliv++;
    endtask

    task automatic test_flush_stall();
        int n; bit ok; logic [31:0] a, d;
        imem_req_ready = 1'b1;
        wait_valid(10, n, ok);
        imem_req_ready = 1'b0;
        FlushD = 1'b1;
        StallD = 1'b1;
        pop_exp(a, d);
        checks++; if (!ok || InstrD !== d || PCD !== 32'h104) begin errors++; $display("FAIL flush_pre: got ok=%b %h/%h expected %h/104", ok, InstrD, PCD, d); end
        n_deliv++;
        @(negedge clk);
        FlushD = 1'b0;
        StallD = 1'b0;
        checks++; if (ValidD !== 1'b0 || InstrD !== NOP) begin errors++; $display("FAIL flush_bubble: got %b %h expected 0 %h", ValidD, InstrD, NOP); end
        checks++; if (PCF !== 32'h108 || imem_req_valid !== 1'b1) begin errors++; $display("FAIL flush_pcf: got %h req=%b expected 108/1", PCF, imem_req_valid); end
    endtask

    task automatic test_wrap();
        int n; bit ok; logic [31:0] a, d;
`ifdef FETCH_PERF_CNT_EN
        logic [31:0] fc0;
`endif
        PCSrcE = 1'b1;
        PCTargetE = 32'hFFFF_FFFC;
        @(negedge clk);
        PCSrcE = 1'b0;
        checks++; if (PCF !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_pcf: got %h expected fffffffc", PCF); end
`ifdef FETCH_PERF_CNT_EN
        fc0 = fetch_count;
`endif
        imem_req_ready = 1'b1;
        wait_valid(10, n, ok);
        imem_req_ready = 1'b0;
        pop_exp(a, d);
        checks++; if (!ok || InstrD !== d || PCD !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_fetch: got ok=%b %h/%h expected %h/fffffffc", ok, InstrD, PCD, d); end
        checks++; if (PCPlus4D !== 32'h0) begin errors++; $display("FAIL wrap_pcplus4: got %h expected 0", PCPlus4D); end
        checks++; if (imem_addr !== 32'h0 || imem_req_valid !== 1'b1) begin errors++; $display("FAIL wrap_next_addr: got %h req=%b expected 0/1", imem_addr, imem_req_valid); end
`ifdef FETCH_PERF_CNT_EN
        checks++; if (fetch_count !== fc0 + 32'd1) begin errors++; $display("FAIL wrap_fetch_count: got %0d expected %0d", fetch_count, fc0 + 32'd1); end
`endif
        n_deliv++;
    endtask

    task automatic test_back_to_back();
        int n; bit ok; logic [31:0] a, d;
        imem_req_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wait_valid(10, n, ok);
            pop_exp(a, d);
            checks++; if (!ok || n != 2) begin errors++; $display("FAIL b2b_gap_%0d: got ok=%b n=%0d expected 1/2", i, ok, n); end
            checks++; if (InstrD !== d || PCD !== 32'(i * 4)) begin errors++; $display("FAIL b2b_ifid_%0d: got %h/%h expected %h/%h", i, InstrD, PCD, d, 32'(i * 4)); end
            n_deliv++;
        end
        imem_req_ready = 1'b0;
    endtask

    task automatic test_redirect_rsp_same();
        int n; bit ok; logic [31:0] a, d;
        imem_req_ready = 1'b1;
        @(negedge clk);
        imem_req_ready = 1'b0;
        PCSrcE = 1'b1;
        PCTargetE = 32'h200;
        @(negedge clk);
        PCSrcE = 1'b0;
        checks++; if (ValidD !== 1'b0 || PCF !== 32'h200) begin errors++; $display("FAIL same_discard: got V=%b pcf=%h expected 0/200", ValidD, PCF); end
        checks++; if (imem_req_valid !== 1'b1 || imem_addr !== 32'h200) begin errors++; $display("FAIL same_req: got req=%b addr=%h expected 1/200", imem_req_valid, imem_addr); end
        pop_exp(a, d);
        n_drop++;
        imem_req_ready = 1'b1;
        wait_valid(10, n, ok);
        imem_req_ready = 1'b0;
        pop_exp(a, d);
        checks++; if (!ok || n != 2 || InstrD !== d || PCD !== 32'h200) begin
            errors++; $display("FAIL same_fetch: got ok=%b n=%0d %h/%h expected 1/2 %h/200", ok, n, InstrD, PCD, d);
        end
        n_deliv++;
    endtask

    task automatic test_perf_counters();
`ifdef FETCH_PERF_CNT_EN
        checks++; if (fetch_count !== 32'(n_deliv)) begin errors++; $display("FAIL perf_fetch: got %0d expected %0d", fetch_count, n_deliv); end
        checks++; if (drop_count !== 32'(n_drop)) begin errors++; $display("FAIL perf_drop: got %0d expected %0d", drop_count, n_drop); end
`endif
    endtask

    task automatic test_reset_mid();
        int n; bit ok; logic [31:0] a, d;
        imem_req_ready = 1'b1;
        wait_valid(10, n, ok);
        pop_exp(a, d);
        checks++; if (!ok || PCD !== 32'h204) begin errors++; $display("FAIL rstmid_pre: got ok=%b pcd=%h expected 1/204", ok, PCD); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (ValidD !== 1'b0 || InstrD !== NOP || PCF !== 32'h0 || imem_req_valid !== 1'b1) begin
            errors++; $display("FAIL rstmid_async: got V=%b %h pcf=%h req=%b expected 0 %h 0 1", ValidD, InstrD, PCF, imem_req_valid, NOP);
        end
        imem_req_ready = 1'b0;
        @(negedge clk);
        exp_q.delete();
        rst_n = 1'b1;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        test_reset();
        test_first_fetch();
        test_req_backpressure();
        test_stall_hold();
        test_redirect_wait();
        test_flush_stall();
        test_wrap();
        test_back_to_back();
        test_redirect_rsp_same();
        test_perf_counters();
        test_reset_mid();
        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
